// File: rtl/mic1_microsequencer_if.sv
// Bus bundle between the MIC-1 microsequencer, its control store and the datapath.
// The master modport is the sequencer side; the slave modport is the store/datapath side.
interface mic1_microsequencer_if #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 36,
    parameter int MBR_W  = 8
);
    logic              cs_ren;
    logic [ADDR_W-1:0] cs_raddr;
    logic [WORD_W-1:0] cs_rdata;
    logic [WORD_W-1:0] mir;
    logic              mir_valid;
    logic              dp_done;
    logic              alu_n;
    logic              alu_z;
    logic [MBR_W-1:0]  mbr;
    logic              stall;
    logic [ADDR_W-1:0] mpc;
    logic              halted;

    modport master (
        output cs_ren, cs_raddr, mir, mir_valid, mpc, halted,
        input  cs_rdata, dp_done, alu_n, alu_z, mbr, stall
    );

    modport slave (
        input  cs_ren, cs_raddr, mir, mir_valid, mpc, halted,
        output cs_rdata, dp_done, alu_n, alu_z, mbr, stall
    );
endinterface

// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: fetches from the control store, holds MPC/MIR and
// forms the next MPC by OR-ing JAMN/JAMZ/JMPC contributions into NEXT_ADDRESS.
module mic1_microsequencer #(
    parameter int                ADDR_W     = 9,
    parameter int                WORD_W     = 36,
    parameter int                MBR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 9'h000
) (
    input logic                   clk,
    input logic                   rst,
    mic1_microsequencer_if.master bus
);
    localparam int NA_LSB   = WORD_W - ADDR_W;
    localparam int JMPC_BIT = NA_LSB - 1;
    localparam int JAMN_BIT = NA_LSB - 2;
    localparam int JAMZ_BIT = NA_LSB - 3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [WORD_W-1:0] mir_q, mir_d;
    logic              mir_valid_q, mir_valid_d;
    logic              halted_q, halted_d;
    logic              cs_ren_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              jam_any_s;

    // Branching is pure OR: JAM flags can only set the MSB, MBR only sets low bits.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] na,
        input logic              jmpc,
        input logic              jamn,
        input logic              jamz,
        input logic              n,
        input logic              z,
        input logic [MBR_W-1:0]  m
    );
        logic [ADDR_W-1:0] t;
        t              = na;
        t[ADDR_W-1]    = t[ADDR_W-1] | (jamn & n) | (jamz & z);
        t[MBR_W-1:0]   = jmpc ? (t[MBR_W-1:0] | m) : t[MBR_W-1:0];
        return t;
    endfunction

    // Next-state, next-MPC and MIR load decisions.
    always_comb begin
        state_d     = state_q;
        mpc_d       = mpc_q;
        mir_d       = mir_q;
        cs_ren_s    = 1'b0;
        jam_any_s   = mir_q[JMPC_BIT] | mir_q[JAMN_BIT] | mir_q[JAMZ_BIT];
        next_addr_s = branch_target(mir_q[WORD_W-1 -: ADDR_W], mir_q[JMPC_BIT],
                                    mir_q[JAMN_BIT], mir_q[JAMZ_BIT],
                                    bus.alu_n, bus.alu_z, bus.mbr);
        case (state_q)
            FETCH: begin
                if (!bus.stall) begin
                    cs_ren_s = 1'b1;
                    state_d  = LOAD;
                end else begin
                    cs_ren_s = 1'b0;
                    state_d  = FETCH;
                end
            end
            LOAD: begin
                mir_d   = bus.cs_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                if (bus.dp_done) begin
                    mpc_d = next_addr_s;
                    // A branch-free jump to itself can never leave; park in HALT.
                    if ((next_addr_s == mpc_q) && !jam_any_s) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        mir_valid_d = (state_d == EXEC);
        halted_d    = (state_d == HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            mpc_q       <= RESET_ADDR;
            mir_q       <= '0;
            mir_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mpc_q       <= mpc_d;
            mir_q       <= mir_d;
            mir_valid_q <= mir_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.cs_ren    = cs_ren_s;
    assign bus.cs_raddr  = mpc_q;
    assign bus.mpc       = mpc_q;
    assign bus.mir       = mir_q;
    assign bus.mir_valid = mir_valid_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_mic1_microsequencer.sv
// Self-checking bench for mic1_microsequencer: directed branching/stall/halt
// steps followed by random microprograms against a transaction-level model.
module tb_mic1_microsequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [35:0] mem [512];
    logic [8:0]  exp_mpc;

    mic1_microsequencer_if #(.ADDR_W(9), .WORD_W(36), .MBR_W(8)) bus ();

    mic1_microsequencer #(
        .ADDR_W(9), .WORD_W(36), .MBR_W(8), .RESET_ADDR(9'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Control store: one-cycle read latency, garbage on idle cycles.
    always @(posedge clk) begin
        if (bus.cs_ren === 1'b1) bus.cs_rdata <= mem[bus.cs_raddr];
        else                     bus.cs_rdata <= 36'({$urandom(), $urandom()});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [8:0] na, input logic j, input logic jn, input logic jz);
        return {na, j, jn, jz, 24'($urandom())};
    endfunction

    // Reference: address bits are OR-ed together as plain integers.
    function automatic int ref_next(input logic [35:0] w, input logic n, input logic z, input int m);
        int a;
        a = int'(w[35:27]);
        if ((w[25] && n) || (w[24] && z)) a = a | 256;
        if (w[26]) a = a | m;
        return a;
    endfunction

    task automatic do_reset(input int cyc);
        rst         = 1'b1;
        bus.dp_done = 1'b1;
        bus.stall   = 1'b0;
        repeat (cyc) tick();
        chk("rst_mpc", 36'(bus.mpc), 36'h0);
        chk("rst_mir", bus.mir, 36'h0);
        chk("rst_mir_valid", 36'(bus.mir_valid), 36'h0);
        chk("rst_halted", 36'(bus.halted), 36'h0);
        rst         = 1'b0;
        bus.dp_done = 1'b0;
        #1;
        chk("rst_first_cs_ren", 36'(bus.cs_ren), 36'h1);
        chk("rst_first_raddr", 36'(bus.cs_raddr), 36'h0);
        tick();
        chk("rst_load_mir_valid", 36'(bus.mir_valid), 36'h0);
        tick();
        chk("rst_exec_mir_valid", 36'(bus.mir_valid), 36'h1);
        chk("rst_exec_mir", bus.mir, mem[0]);
        exp_mpc = 9'h000;
    endtask

    // One microinstruction retirement; returns with the DUT in EXEC unless halted.
    task automatic step(input logic n, input logic z, input logic [7:0] m,
                        input int stall_cyc, input bit load_done, output bit halt);
        logic [35:0] w;
        int          nxt;
        w    = mem[exp_mpc];
        nxt  = ref_next(w, n, z, int'(m));
        halt = (nxt == int'(exp_mpc)) && (w[26:24] == 3'b000);
        bus.alu_n   = n;
        bus.alu_z   = z;
        bus.mbr     = m;
        bus.dp_done = 1'b1;
        bus.stall   = (stall_cyc > 0);
        tick();
        bus.dp_done = 1'b0;
        bus.alu_n   = 1'($urandom());
        bus.alu_z   = 1'($urandom());
        bus.mbr     = 8'($urandom());
        chk("next_mpc", 36'(bus.mpc), 36'(nxt));
        chk("next_raddr", 36'(bus.cs_raddr), 36'(nxt));
        chk("next_halted", 36'(bus.halted), 36'(halt));
        chk("fetch_mir_valid", 36'(bus.mir_valid), 36'h0);
        exp_mpc = 9'(nxt);
        if (halt) begin
            chk("halt_cs_ren", 36'(bus.cs_ren), 36'h0);
            bus.stall = 1'b0;
            return;
        end
        for (int i = 0; i < stall_cyc; i++) begin
            chk("stall_cs_ren", 36'(bus.cs_ren), 36'h0);
            chk("stall_mpc", 36'(bus.mpc), 36'(nxt));
            tick();
        end
        bus.stall = 1'b0;
        #1;
        chk("fetch_cs_ren", 36'(bus.cs_ren), 36'h1);
        tick();
        chk("load_mir_valid", 36'(bus.mir_valid), 36'h0);
        bus.dp_done = load_done;
        tick();
        bus.dp_done = 1'b0;
        chk("exec_mpc", 36'(bus.mpc), 36'(nxt));
        chk("exec_mir_valid", 36'(bus.mir_valid), 36'h1);
        chk("exec_mir", bus.mir, mem[nxt]);
    endtask

    initial begin
        bit h;
        bus.dp_done = 1'b0;
        bus.stall   = 1'b0;
        bus.alu_n   = 1'b0;
        bus.alu_z   = 1'b0;
        bus.mbr     = 8'h00;
        for (int i = 0; i < 512; i++) mem[i] = 36'({$urandom(), $urandom()});
        mem[9'h000] = mk(9'h005, 1'b0, 1'b0, 1'b0);
        mem[9'h005] = mk(9'h010, 1'b0, 1'b0, 1'b1);
        mem[9'h110] = mk(9'h010, 1'b0, 1'b0, 1'b1);
        mem[9'h010] = mk(9'h120, 1'b0, 1'b1, 1'b0);
        mem[9'h120] = mk(9'h000, 1'b1, 1'b0, 1'b0);
        mem[9'h060] = mk(9'h100, 1'b1, 1'b0, 1'b0);
        mem[9'h1FF] = mk(9'h030, 1'b0, 1'b0, 1'b0);
        mem[9'h030] = mk(9'h007, 1'b0, 1'b0, 1'b0);
        mem[9'h007] = mk(9'h007, 1'b0, 1'b0, 1'b0);

        do_reset(2);
        step(1'b1, 1'b1, 8'hA5, 0, 1'b0, h);  // plain: 0x000 -> 0x005
        step(1'b0, 1'b1, 8'h3C, 0, 1'b0, h);  // JAMZ taken -> 0x110
        step(1'b1, 1'b0, 8'h00, 0, 1'b0, h);  // JAMZ not taken -> 0x010
        step(1'b1, 1'b0, 8'h00, 0, 1'b0, h);  // JAMN, bit 8 already set -> 0x120
        step(1'b0, 1'b0, 8'h60, 0, 1'b0, h);  // JMPC -> 0x060
        step(1'b1, 1'b1, 8'hFF, 0, 1'b0, h);  // JMPC -> 0x1FF
        step(1'b0, 1'b0, 8'h5A, 3, 1'b1, h);  // stall in FETCH, dp_done in LOAD -> 0x030
        step(1'b0, 1'b0, 8'h00, 0, 1'b0, h);  // -> 0x007
        step(1'b1, 1'b1, 8'hFF, 0, 1'b0, h);  // self-loop -> HALT
        chk("halt_expected", 36'(h), 36'h1);
        for (int i = 0; i < 3; i++) begin
            bus.dp_done = 1'b1;
            bus.mbr     = 8'($urandom());
            tick();
            chk("halt_hold_mpc", 36'(bus.mpc), 36'h007);
            chk("halt_hold_halted", 36'(bus.halted), 36'h1);
            chk("halt_hold_cs_ren", 36'(bus.cs_ren), 36'h0);
            chk("halt_hold_mir_valid", 36'(bus.mir_valid), 36'h0);
        end
        bus.dp_done = 1'b0;
        do_reset(1);  // out of HALT
        do_reset(1);  // mid-EXEC

        for (int i = 0; i < 512; i++) begin
            case ($urandom_range(0, 15))
                0:       mem[i] = mk(9'(i), 1'b0, 1'b0, 1'b0);
                1:       mem[i] = {9'(i), 3'($urandom_range(1, 7)), 24'($urandom())};
                default: mem[i] = 36'({$urandom(), $urandom()});
            endcase
        end
        do_reset(1);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom()), 1'($urandom()), 8'($urandom()),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     1'($urandom()), h);
                if (h) begin
                    bus.dp_done = 1'b1;
                    tick();
                    bus.dp_done = 1'b0;
                    chk("rand_halt_mpc", 36'(bus.mpc), 36'(exp_mpc));
                    chk("rand_halt_halted", 36'(bus.halted), 36'h1);
                    do_reset(1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
